full_adder: RTL and testbench

Single-bit (parameterisable-width) binary full adder used as the basic arithmetic cell in the datapath. It produces a purely combinational sum and carry-out from operands `a`, `b` and carry-in `cin`, and also registers that result on the system clock for pipelined consumers. With default parameters the combinational ports form a drop-in 1-bit full adder connected positionally as (a, b, cin, sum, cout).

---
 rtl/full_adder.sv | 47 ++++
 tb/tb_full_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Ripple-carry full adder with a combinational result and a registered copy.
// With WIDTH=1 the first five ports form a plain 1-bit full adder.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  // Ripple the carry through WIDTH full-adder cells, LSB first.
  always_comb begin
    carry    = '0;
    sum_d    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]   = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    cout_d = carry[WIDTH];
  end

  assign sum  = sum_d;
  assign cout = cout_d;

  // Capture the combinational result each rising edge; reset clears it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: 1-bit and 4-bit instances sharing clock and reset.
module tb_full_adder;

  logic       clk;
  logic       rst;

  logic       a1, b1, cin1;
  logic       sum1, cout1, sum1_q, cout1_q;

  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] sum4, sum4_q;
  logic       cout4, cout4_q;

  int n_checks;
  int n_fail;

  full_adder #(.WIDTH(1)) dut1 (
    .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1),
    .clk(clk), .rst(rst), .sum_q(sum1_q), .cout_q(cout1_q)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(cout4),
    .clk(clk), .rst(rst), .sum_q(sum4_q), .cout_q(cout4_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    #2;
    n_checks++;
    if ({cout1_q, sum1_q} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_w1: got %b expected 00", {cout1_q, sum1_q});
    end
    n_checks++;
    if ({cout4_q, sum4_q} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_w4: got %b expected 00000", {cout4_q, sum4_q});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truth_table;
    logic [7:0] tt_sum;
    logic [7:0] tt_cout;
    logic [2:0] v;
    tt_sum  = 8'b1001_0110;
    tt_cout = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin1} = v;
      #1;
      n_checks++;
      if (sum1 !== tt_sum[i] || cout1 !== tt_cout[i]) begin
        n_fail++;
        $display("FAIL truth_table abc=%b: got sum=%b cout=%b expected sum=%b cout=%b",
                 v, sum1, cout1, tt_sum[i], tt_cout[i]);
      end
      #9;
    end
  endtask

  task automatic test_latency;
    @(negedge clk);
    {a1, b1, cin1} = 3'b000;
    @(posedge clk);
    @(negedge clk);
    {a1, b1, cin1} = 3'b110;
    #1;
    n_checks++;
    if ({cout1_q, sum1_q} !== 2'b00) begin
      n_fail++;
      $display("FAIL latency_before: got cout_q,sum_q=%b expected 00", {cout1_q, sum1_q});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({cout1_q, sum1_q} !== 2'b10) begin
      n_fail++;
      $display("FAIL latency_after: got cout_q,sum_q=%b expected 10", {cout1_q, sum1_q});
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    {a1, b1, cin1} = 3'b100;
    @(posedge clk);
    #1;
    n_checks++;
    if ({cout1_q, sum1_q} !== 2'b01) begin
      n_fail++;
      $display("FAIL areset_preload: got %b expected 01", {cout1_q, sum1_q});
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cout1_q, sum1_q} !== 2'b00) begin
      n_fail++;
      $display("FAIL areset_clear: got %b expected 00", {cout1_q, sum1_q});
    end
    {a1, b1, cin1} = 3'b010;
    #1;
    n_checks++;
    if ({cout1, sum1} !== 2'b01 || {cout1_q, sum1_q} !== 2'b00) begin
      n_fail++;
      $display("FAIL areset_comb: got cout,sum=%b q=%b expected 01 q=00",
               {cout1, sum1}, {cout1_q, sum1_q});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({cout1_q, sum1_q} !== 2'b00) begin
      n_fail++;
      $display("FAIL areset_hold: got %b expected 00", {cout1_q, sum1_q});
    end
    @(negedge clk);
    rst = 1'b0;
    {a1, b1, cin1} = 3'b101;
    @(posedge clk);
    #1;
    n_checks++;
    if ({cout1_q, sum1_q} !== 2'b10) begin
      n_fail++;
      $display("FAIL areset_release: got %b expected 10", {cout1_q, sum1_q});
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    #1;
    n_checks++;
    if ({cout4, sum4} !== 5'b1_0000) begin
      n_fail++;
      $display("FAIL wrap_f01: got %b expected 10000", {cout4, sum4});
    end
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0;
    #1;
    n_checks++;
    if ({cout4, sum4} !== 5'b0_1111) begin
      n_fail++;
      $display("FAIL wrap_780: got %b expected 01111", {cout4, sum4});
    end
  endtask

  task automatic test_random;
    logic [4:0] exp_q[$];
    logic [4:0] e;
    logic [4:0] r;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a4   = 4'($urandom_range(0, 15));
      b4   = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom_range(0, 1));
      e = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
      exp_q.push_back(e);
      #1;
      n_checks++;
      if ({cout4, sum4} !== e) begin
        n_fail++;
        $display("FAIL random_comb %0d: a=%h b=%h cin=%b got %b expected %b",
                 i, a4, b4, cin4, {cout4, sum4}, e);
      end
      @(posedge clk);
      #1;
      r = exp_q.pop_front();
      n_checks++;
      if ({cout4_q, sum4_q} !== r) begin
        n_fail++;
        $display("FAIL random_reg %0d: got %b expected %b", i, {cout4_q, sum4_q}, r);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    test_reset();
    test_truth_table();
    test_latency();
    test_async_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
